// File: rtl/rv_wb_pkg.sv
// rtl/rv_wb_pkg.sv - writeback-select encodings, load funct3 codes and FSM states
package rv_wb_pkg;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_MEM  = 2'b10;
  localparam logic [1:0] WB_PC4  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane selection and sign/zero extension
module load_extend
  import rv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/half, then extend according to the load type;
  // unknown funct3 codes fall back to a full-word load.
  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
    word      = rdata;
    case (funct3)
      F3_LB:   word = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LH:   word = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LBU:  word = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LHU:  word = {{(XLEN-16){1'b0}}, half_lane};
      default: word = rdata;
    endcase
  end

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - writeback stage: result select, load extend, one registered RF write (forwarding via RF_WB_FORWARD_EN)
module rf_writeback
  import rv_wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [1:0]      ex_wbsel,
  input  logic [XLEN-1:0] ex_alu,
  input  logic [XLEN-1:0] ex_pc4,
  input  logic [2:0]      ex_funct3,
  input  logic [1:0]      ex_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  wb_state_t       state;
  logic [RA_W-1:0] pend_rd;
  logic [2:0]      pend_funct3;
  logic [1:0]      pend_addr_lo;
  logic [XLEN-1:0] load_word;
  logic            accept;

  assign accept = ex_valid && ex_ready;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata   (mem_rdata),
    .funct3  (pend_funct3),
    .addr_lo (pend_addr_lo),
    .word    (load_word)
  );

  // Writeback FSM: every output is registered so the RF write lands exactly
  // one cycle after the accept (ALU/PC+4) or after mem_rvalid (loads).
  // A load's rd is parked in pend_* so rf_waddr/rf_wdata stay untouched while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ex_ready     <= 1'b1;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      pend_rd      <= '0;
      pend_funct3  <= '0;
      pend_addr_lo <= '0;
    end else begin
      rf_we <= 1'b0;
      if (accept) begin
        case (ex_wbsel)
          WB_ALU, WB_PC4: begin
            state    <= ST_WRITE;
            ex_ready <= 1'b1;
            rf_we    <= (ex_rd != '0);
            rf_waddr <= ex_rd;
            rf_wdata <= (ex_wbsel == WB_ALU) ? ex_alu : ex_pc4;
          end
          WB_MEM: begin
            state        <= ST_WAIT_MEM;
            ex_ready     <= 1'b0;
            pend_rd      <= ex_rd;
            pend_funct3  <= ex_funct3;
            pend_addr_lo <= ex_addr_lo;
          end
          default: begin
            state    <= ST_IDLE;
            ex_ready <= 1'b1;
          end
        endcase
      end else if (state == ST_WAIT_MEM && mem_rvalid) begin
        state    <= ST_WRITE;
        ex_ready <= 1'b1;
        rf_we    <= (pend_rd != '0);
        rf_waddr <= pend_rd;
        rf_wdata <= load_word;
      end else if (state == ST_WRITE) begin
        state    <= ST_IDLE;
        ex_ready <= 1'b1;
      end
    end
  end

`ifdef RF_WB_FORWARD_EN
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed self-checking bench for rf_writeback
module tb_rf_writeback;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wbsel;
  logic [31:0] ex_alu;
  logic [31:0] ex_pc4;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int checks;
  int failures;

  rf_writeback #(.XLEN(32), .RA_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_rd      (ex_rd),
    .ex_wbsel   (ex_wbsel),
    .ex_alu     (ex_alu),
    .ex_pc4     (ex_pc4),
    .ex_funct3  (ex_funct3),
    .ex_addr_lo (ex_addr_lo),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    ex_rd      = 5'd0;
    ex_wbsel   = 2'b00;
    ex_alu     = 32'h0;
    ex_pc4     = 32'h0;
    ex_funct3  = 3'b000;
    ex_addr_lo = 2'b00;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (ex_ready !== 1'b1 || rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%b we=%b waddr=%0d wdata=%h required ready=1 we=0 waddr=0 wdata=0",
               ex_ready, rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_fwd: fwd=%b/%0d/%h required 0/0/0", fwd_valid, fwd_rd, fwd_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu(input logic [1:0] sel, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc4,
                          input logic [31:0] exp_data);
    ex_valid = 1'b1;
    ex_wbsel = sel;
    ex_rd    = rd;
    ex_alu   = alu;
    ex_pc4   = pc4;
    checks++;
    if (ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL alu_ready_idle: ready=%b required 1", ex_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== rd || rf_wdata !== exp_data) begin
      failures++;
      $display("FAIL alu_write sel=%b: we=%b waddr=%0d wdata=%h required we=1 waddr=%0d wdata=%h",
               sel, rf_we, rf_waddr, rf_wdata, rd, exp_data);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== rd || rf_wdata !== exp_data) begin
      failures++;
      $display("FAIL alu_after: we=%b waddr=%0d wdata=%h required we=0 waddr=%0d wdata=%h (held)",
               rf_we, rf_waddr, rf_wdata, rd, exp_data);
    end
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] raw, input logic [31:0] exp_data);
    ex_valid   = 1'b1;
    ex_wbsel   = 2'b10;
    ex_rd      = 5'd7;
    ex_funct3  = f3;
    ex_addr_lo = lo;
    // data offered in the acceptance cycle must be ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5A5A_A5A5;
    tick();
    idle_inputs();
    checks++;
    if (ex_ready !== 1'b0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL %s wait1: ready=%b we=%b required ready=0 we=0", name, ex_ready, rf_we);
    end
    // an instruction presented while waiting must not be taken
    ex_valid = 1'b1;
    ex_wbsel = 2'b01;
    ex_rd    = 5'd12;
    ex_alu   = 32'hBAD0_BAD0;
    tick();
    idle_inputs();
    checks++;
    if (ex_ready !== 1'b0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL %s wait2: ready=%b we=%b required ready=0 we=0", name, ex_ready, rf_we);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = raw;
    tick();
    idle_inputs();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== exp_data || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s write: we=%b waddr=%0d wdata=%h ready=%b required we=1 waddr=7 wdata=%h ready=1",
               name, rf_we, rf_waddr, rf_wdata, ex_ready, exp_data);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after: we=%b ready=%b required we=0 ready=1", name, rf_we, ex_ready);
    end
  endtask

  task automatic test_no_write();
    ex_valid = 1'b1;
    ex_wbsel = 2'b01;
    ex_rd    = 5'd0;
    ex_alu   = 32'hFFFF_FFFF;
    tick();
    ex_wbsel = 2'b00;
    ex_rd    = 5'd9;
    ex_alu   = 32'h0000_0009;
    checks++;
    if (rf_we !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd0_write: we=%b ready=%b required we=0 ready=1", rf_we, ex_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (rf_we !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL wbsel_none: we=%b ready=%b required we=0 ready=1", rf_we, ex_ready);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL none_after: we=%b ready=%b required we=0 ready=1", rf_we, ex_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    for (int i = 1; i <= 3; i++) begin
      ex_valid = 1'b1;
      ex_wbsel = 2'b01;
      ex_rd    = 5'(i);
      ex_alu   = 32'h1111_0000 * i + 32'(i);
      tick();
      exp_data = 32'h1111_0000 * i + 32'(i);
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== exp_data || ex_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_write%0d: we=%b waddr=%0d wdata=%h ready=%b required we=1 waddr=%0d wdata=%h ready=1",
                 i, rf_we, rf_waddr, rf_wdata, ex_ready, i, exp_data);
      end
      checks++;
`ifdef RF_WB_FORWARD_EN
      if (fwd_valid !== 1'b1 || fwd_rd !== 5'(i) || fwd_data !== exp_data) begin
        failures++;
        $display("FAIL b2b_fwd%0d: fwd=%b/%0d/%h required 1/%0d/%h",
                 i, fwd_valid, fwd_rd, fwd_data, i, exp_data);
      end
`else
      if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'h0) begin
        failures++;
        $display("FAIL b2b_fwd%0d: fwd=%b/%0d/%h required 0/0/0", i, fwd_valid, fwd_rd, fwd_data);
      end
`endif
    end
    idle_inputs();
    tick();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd3) begin
      failures++;
      $display("FAIL b2b_end: we=%b waddr=%0d required we=0 waddr=3", rf_we, rf_waddr);
    end
  endtask

  task automatic test_reset_midflight();
    // reset while waiting for load data, then a late mem_rvalid
    ex_valid  = 1'b1;
    ex_wbsel  = 2'b10;
    ex_rd     = 5'd4;
    ex_funct3 = 3'b010;
    tick();
    idle_inputs();
    tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if (ex_ready !== 1'b1 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_async: ready=%b we=%b required ready=1 we=0", ex_ready, rf_we);
    end
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_late: we=%b ready=%b required we=0 ready=1", rf_we, ex_ready);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || ex_ready !== 1'b1 || rf_wdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_wait_idle: we=%b ready=%b wdata=%h required we=0 ready=1 wdata=0",
               rf_we, ex_ready, rf_wdata);
    end
    // reset during the write cycle kills the write at once
    ex_valid = 1'b1;
    ex_wbsel = 2'b01;
    ex_rd    = 5'd6;
    ex_alu   = 32'h0000_0066;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if (rf_we !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_write: we=%b ready=%b required we=0 ready=1", rf_we, ex_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_alu(2'b01, 5'd5, 32'h1234_5678, 32'h0000_1004, 32'h1234_5678);
    test_alu(2'b11, 5'd31, 32'hDEAD_0000, 32'h0000_2008, 32'h0000_2008);
    test_load("lb3",  3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
    test_load("lbu3", 3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080);
    test_load("lb1",  3'b000, 2'd1, 32'h80FF_7F00, 32'h0000_007F);
    test_load("lbu2", 3'b100, 2'd2, 32'h80FF_0000, 32'h0000_00FF);
    test_load("lh2",  3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
    test_load("lhu2", 3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001);
    test_load("lh3",  3'b001, 2'd3, 32'h8001_0000, 32'hFFFF_8001);
    test_load("lhu0", 3'b101, 2'd0, 32'h1234_F00D, 32'h0000_F00D);
    test_load("lw",   3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    test_load("f3_011", 3'b011, 2'd1, 32'h8765_4321, 32'h8765_4321);
    test_no_write();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
